// File: rtl/ft600_device_model.sv
// Device-side model of a 32-bit FT245-style synchronous FIFO bus.
// Two buffers: the read buffer carries host_in words to the master, and the
// write buffer carries {be, data} words captured from the master to host_out.
//
// Handshakes: a word moves on a rising edge only when valid && ready are both
// high. valid must not depend on ready. host_in_ready = !read_full.
// host_out_valid = !write_empty, and host_out_* show the head word.
module ft600_device_model #(
  parameter int RD_AW       = 11,
  parameter int WR_AW       = 11,
  parameter int PACKET_SIZE = 1024
) (
  input  logic        usb_clk,
  input  logic        rst,
  output logic        usb_rxf,
  output logic        usb_txe,
  input  logic        usb_oe,
  input  logic        usb_rd,
  input  logic        usb_wr,
  inout  wire  [31:0] usb_data,
  inout  wire  [3:0]  usb_be,
  input  logic [31:0] host_in_data,
  input  logic        host_in_valid,
  output logic        host_in_ready,
  output logic [31:0] host_out_data,
  output logic [3:0]  host_out_be,
  output logic        host_out_valid,
  input  logic        host_out_ready,
  output logic [15:0] underrun_cnt,
  output logic [15:0] overflow_cnt,
  output logic        proto_err,
  output logic [3:0]  bus_state
);

  localparam int RD_DEPTH = 1 << RD_AW;
  localparam int WR_DEPTH = 1 << WR_AW;
  localparam logic [RD_AW:0] RD_FULL = {1'b1, {RD_AW{1'b0}}};
  localparam logic [WR_AW:0] WR_FULL = {1'b1, {WR_AW{1'b0}}};
  localparam logic [WR_AW:0] PKT     = (WR_AW+1)'(PACKET_SIZE);

  typedef enum logic [3:0] {
    BUS_IDLE  = 4'b0001,
    BUS_OE    = 4'b0010,
    BUS_READ  = 4'b0100,
    BUS_WRITE = 4'b1000
  } bus_state_t;

  bus_state_t state, state_n;
  logic       err_set;

  // Read buffer (host -> master)
  logic [31:0]      rd_mem [RD_DEPTH];
  logic [RD_AW-1:0] rd_wptr, rd_rptr;
  logic [RD_AW:0]   rd_cnt;
  logic [31:0]      last_word;
  logic             rd_empty, rd_full, rd_push, rd_pop, bus_rd_req;

  // Write buffer (master -> host), each entry {be, data}
  logic [35:0]      wr_mem [WR_DEPTH];
  logic [WR_AW-1:0] wr_wptr, wr_rptr;
  logic [WR_AW:0]   wr_cnt;
  logic [35:0]      wr_head;
  logic             wr_empty, wr_full, wr_push, wr_pop, bus_wr_req;

  logic        drive;
  logic [31:0] bus_word;

  assign rd_empty   = (rd_cnt == '0);
  assign rd_full    = (rd_cnt == RD_FULL);
  assign wr_empty   = (wr_cnt == '0);
  assign wr_full    = (wr_cnt == WR_FULL);

  assign bus_rd_req = usb_oe && usb_rd && !usb_wr;
  assign bus_wr_req = usb_wr && !usb_oe;
  assign rd_push    = host_in_valid && !rd_full;
  assign rd_pop     = bus_rd_req && !rd_empty;
  assign wr_push    = bus_wr_req && !wr_full;
  assign wr_pop     = host_out_ready && !wr_empty;

  assign usb_rxf        = !rd_empty;
  assign usb_txe        = (WR_FULL - wr_cnt) >= PKT;
  assign host_in_ready  = !rd_full;
  assign host_out_valid = !wr_empty;
  assign wr_head        = wr_mem[wr_rptr];
  assign host_out_data  = wr_empty ? 32'd0 : wr_head[31:0];
  assign host_out_be    = wr_empty ? 4'd0  : wr_head[35:32];
  assign bus_state      = state;

  // The model owns the bus only while the master asks for data and is not writing.
  // An empty buffer keeps showing the last word the master consumed.
  assign drive    = usb_oe && !usb_wr;
  assign bus_word = rd_empty ? last_word : rd_mem[rd_rptr];
  assign usb_data = drive ? bus_word : 32'bz;
  assign usb_be   = drive ? 4'hF : 4'bz;

  // Buffer storage writes; pointers are reset, so contents need no reset.
  always_ff @(posedge usb_clk) begin
    if (rd_push) rd_mem[rd_wptr] <= host_in_data;
    if (wr_push) wr_mem[wr_wptr] <= {usb_be, usb_data};
  end

  // Read buffer pointers, occupancy and last consumed word.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      rd_wptr   <= '0;
      rd_rptr   <= '0;
      rd_cnt    <= '0;
      last_word <= '0;
    end else begin
      if (rd_push) rd_wptr <= rd_wptr + 1'b1;
      if (rd_pop) begin
        rd_rptr   <= rd_rptr + 1'b1;
        last_word <= rd_mem[rd_rptr];
      end
      case ({rd_push, rd_pop})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  // Write buffer pointers and occupancy.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      wr_wptr <= '0;
      wr_rptr <= '0;
      wr_cnt  <= '0;
    end else begin
      if (wr_push) wr_wptr <= wr_wptr + 1'b1;
      if (wr_pop)  wr_rptr <= wr_rptr + 1'b1;
      case ({wr_push, wr_pop})
        2'b10:   wr_cnt <= wr_cnt + 1'b1;
        2'b01:   wr_cnt <= wr_cnt - 1'b1;
        default: wr_cnt <= wr_cnt;
      endcase
    end
  end

  // Saturating error counters and the sticky protocol flag.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      underrun_cnt <= '0;
      overflow_cnt <= '0;
      proto_err    <= 1'b0;
    end else begin
      if (bus_rd_req && rd_empty && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
      if (bus_wr_req && wr_full && overflow_cnt != 16'hFFFF)
        overflow_cnt <= overflow_cnt + 16'd1;
      if (err_set) proto_err <= 1'b1;
    end
  end

  // Bus FSM state register.
  always_ff @(posedge usb_clk) begin
    if (rst) state <= BUS_IDLE;
    else     state <= state_n;
  end

  // Bus FSM next state and protocol-violation detection.
  always_comb begin
    state_n = state;
    err_set = 1'b0;
    if (usb_oe && usb_wr) begin
      state_n = BUS_IDLE;
      err_set = 1'b1;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (usb_rd && !usb_oe) err_set = 1'b1;
          if (usb_oe)      state_n = BUS_OE;
          else if (usb_wr) state_n = BUS_WRITE;
        end
        BUS_OE: begin
          if (!usb_oe)     state_n = BUS_IDLE;
          else if (usb_rd) state_n = BUS_READ;
        end
        BUS_READ:  if (!usb_oe) state_n = BUS_IDLE;
        BUS_WRITE: if (!usb_wr) state_n = BUS_IDLE;
        default:   state_n = BUS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft600_device_model.sv
// Bench for ft600_device_model: directed scenarios plus randomized bursts,
// checked every cycle against a queue-based model of both buffers.
module tb_ft600_device_model;

  localparam int RDEPTH = 2048;
  localparam int WDEPTH = 2048;
  localparam int PKT    = 1024;
  localparam int M_IDLE = 0, M_OE = 1, M_READ = 2, M_WRITE = 3;

  // ---------------- clock / reset ----------------
  logic usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  logic        rst, usb_oe, usb_rd, usb_wr;
  logic        tb_drv;
  logic [31:0] tb_data;
  logic [3:0]  tb_be;
  wire  [31:0] usb_data;
  wire  [3:0]  usb_be;
  logic        usb_rxf, usb_txe;
  logic [31:0] host_in_data, host_out_data;
  logic        host_in_valid, host_in_ready, host_out_valid, host_out_ready;
  logic [3:0]  host_out_be;
  logic [15:0] underrun_cnt, overflow_cnt;
  logic        proto_err;
  logic [3:0]  bus_state;

  assign usb_data = tb_drv ? tb_data : 32'bz;
  assign usb_be   = tb_drv ? tb_be : 4'bz;

  ft600_device_model #(.RD_AW(11), .WR_AW(11), .PACKET_SIZE(PKT)) dut (
    .usb_clk(usb_clk), .rst(rst), .usb_rxf(usb_rxf), .usb_txe(usb_txe),
    .usb_oe(usb_oe), .usb_rd(usb_rd), .usb_wr(usb_wr),
    .usb_data(usb_data), .usb_be(usb_be),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_be(host_out_be),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .underrun_cnt(underrun_cnt), .overflow_cnt(overflow_cnt),
    .proto_err(proto_err), .bus_state(bus_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [31:0] rd_exp_q[$];
  logic [35:0] wr_exp_q[$];
  logic [31:0] m_last;
  logic [15:0] m_under, m_over;
  logic        m_err;
  int          m_mode;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit oe, input bit wr, input logic [31:0] bd);
    check("rxf", usb_rxf, rd_exp_q.size() != 0);
    check("txe", usb_txe, (WDEPTH - wr_exp_q.size()) >= PKT);
    check("in_ready", host_in_ready, rd_exp_q.size() < RDEPTH);
    check("out_valid", host_out_valid, wr_exp_q.size() != 0);
    if (wr_exp_q.size() != 0) begin
      check("out_data", host_out_data, wr_exp_q[0][31:0]);
      check("out_be", host_out_be, wr_exp_q[0][35:32]);
    end
    check("underrun", underrun_cnt, m_under);
    check("overflow", overflow_cnt, m_over);
    check("proto_err", proto_err, m_err);
    check("bus_onehot", $onehot(bus_state), 1);
    if (oe && !wr) begin
      check("bus_data", usb_data, (rd_exp_q.size() != 0) ? rd_exp_q[0] : m_last);
      check("bus_be", usb_be, 4'hF);
    end else if (wr) begin
      check("bus_wdata", usb_data, bd);
    end
  endtask

  // Apply the effect of one rising edge to the model.
  task automatic model_edge(input bit r, input bit oe, input bit rd, input bit wr,
                            input logic [31:0] bd, input logic [3:0] bb,
                            input bit hv, input logic [31:0] hd, input bit hr);
    bit pop_bus, push_host, cap, hpop, rfull_pre, rempty_pre, wfull_pre;
    logic [35:0] dummy;
    if (r) begin
      rd_exp_q.delete();
      wr_exp_q.delete();
      m_last = '0; m_under = '0; m_over = '0; m_err = 1'b0; m_mode = M_IDLE;
    end else begin
      rempty_pre = (rd_exp_q.size() == 0);
      rfull_pre  = (rd_exp_q.size() >= RDEPTH);
      wfull_pre  = (wr_exp_q.size() >= WDEPTH);
      pop_bus    = oe && rd && !wr;
      push_host  = hv && !rfull_pre;
      cap        = wr && !oe;
      hpop       = hr && (wr_exp_q.size() != 0);
      if (pop_bus) begin
        if (!rempty_pre) m_last = rd_exp_q.pop_front();
        else if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
      end
      if (push_host) rd_exp_q.push_back(hd);
      if (hpop) dummy = wr_exp_q.pop_front();
      if (cap) begin
        if (!wfull_pre) wr_exp_q.push_back({bb, bd});
        else if (m_over != 16'hFFFF) m_over = m_over + 16'd1;
      end
      if (oe && wr) begin
        m_err = 1'b1;
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (rd && !oe) m_err = 1'b1;
        if (oe) m_mode = M_OE;
        else if (wr) m_mode = M_WRITE;
      end else if (m_mode == M_OE) begin
        if (!oe) m_mode = M_IDLE;
        else if (rd) m_mode = M_READ;
      end else if (m_mode == M_READ) begin
        if (!oe) m_mode = M_IDLE;
      end else begin
        if (!wr) m_mode = M_IDLE;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives inputs, checks, then steps one edge.
  task automatic cycle(input bit r, input bit oe, input bit rd, input bit wr,
                       input logic [31:0] bd, input logic [3:0] bb,
                       input bit hv, input logic [31:0] hd, input bit hr, input bit chk);
    rst = r; usb_oe = oe; usb_rd = rd; usb_wr = wr;
    tb_drv = wr; tb_data = bd; tb_be = bb;
    host_in_valid = hv; host_in_data = hd; host_out_ready = hr;
    #1;
    if (chk) check_outputs(oe, wr, bd);
    @(posedge usb_clk);
    model_edge(r, oe, rd, wr, bd, bb, hv, hd, hr);
    #1;
  endtask

  task automatic tick(input bit oe, input bit rd, input bit wr,
                      input logic [31:0] bd, input logic [3:0] bb,
                      input bit hv, input logic [31:0] hd, input bit hr);
    cycle(1'b0, oe, rd, wr, bd, bb, hv, hd, hr, 1'b1);
  endtask

  task automatic idle(input int n, input bit hr);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 32'd0, 4'd0, 0, 32'd0, hr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_last = '0; m_under = '0; m_over = '0; m_err = 1'b0; m_mode = M_IDLE;
    cycle(1, 0, 0, 0, 32'd0, 4'd0, 0, 32'd0, 0, 1'b0);
    cycle(1, 0, 0, 0, 32'd0, 4'd0, 0, 32'd0, 0, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_rxf", usb_rxf, 0);
    check("rst_txe", usb_txe, 1);
    check("rst_in_ready", host_in_ready, 1);
    check("rst_out_valid", host_out_valid, 0);
    check("rst_out_data", host_out_data, 0);
    check("rst_out_be", host_out_be, 0);
    check("rst_underrun", underrun_cnt, 0);
    check("rst_proto", proto_err, 0);

    // Four words through the read buffer.
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 32'd0, 4'd0, 1, 32'h1000 + i, 0);
    tick(1, 0, 0, 32'd0, 4'd0, 0, 32'd0, 0);
    check("t1_first_word", usb_data, 32'h1000);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 32'd0, 4'd0, 0, 32'd0, 0);
    check("t1_rxf_low", usb_rxf, 0);
    check("t1_underrun", underrun_cnt, 0);
    idle(1, 0);

    // Underrun on an empty read buffer.
    tick(1, 0, 0, 32'd0, 4'd0, 0, 32'd0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 32'd0, 4'd0, 0, 32'd0, 0);
    check("t4_underrun", underrun_cnt, 5);
    check("t4_last_word", usb_data, 32'h1003);
    check("t4_no_proto", proto_err, 0);
    idle(1, 0);

    // Bus conflict: oe and wr together.
    tick(1, 0, 1, 32'h5A5A_5A5A, 4'h3, 0, 32'd0, 0);
    check("t5_proto", proto_err, 1);
    idle(3, 0);
    check("t5_proto_sticky", proto_err, 1);
    check("t5_no_capture", host_out_valid, 0);

    // Write burst of one packet: usb_txe holds at exactly PACKET_SIZE free.
    for (int i = 0; i < 1024; i++) tick(0, 0, 1, i, 4'hF, 0, 32'd0, 0);
    check("t2_txe_at_pkt", usb_txe, 1);
    tick(0, 0, 1, 32'd1024, 4'hF, 0, 32'd0, 0);
    check("t2_txe_low", usb_txe, 0);
    check("t2_head", host_out_data, 0);
    idle(1026, 1);
    check("t2_drained", host_out_valid, 0);

    // Overflow of the write buffer.
    for (int i = 0; i < WDEPTH; i++)
      tick(0, 0, 1, 32'h5000_0000 + i, 4'($urandom_range(0, 15)), 0, 32'd0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 32'hDEAD_0000 + i, 4'hF, 0, 32'd0, 0);
    check("t3_overflow", overflow_cnt, 3);
    check("t3_head", host_out_data, 32'h5000_0000);
    idle(WDEPTH + 1, 1);

    // Reset in the middle of a read burst.
    for (int i = 0; i < 512; i++) tick(0, 0, 0, 32'd0, 4'd0, 1, $urandom, 0);
    tick(1, 0, 0, 32'd0, 4'd0, 0, 32'd0, 0);
    for (int i = 0; i < 200; i++) tick(1, 1, 0, 32'd0, 4'd0, 0, 32'd0, 0);
    cycle(1, 1, 1, 0, 32'd0, 4'd0, 1, 32'h7777, 1, 1'b1);
    usb_oe = 0; usb_rd = 0; host_in_valid = 0; host_out_ready = 0;
    #1;
    check("t6_rxf", usb_rxf, 0);
    check("t6_underrun", underrun_cnt, 0);
    check("t6_overflow", overflow_cnt, 0);
    check("t6_proto", proto_err, 0);
    check("t6_out_valid", host_out_valid, 0);
    tick(0, 0, 0, 32'd0, 4'd0, 1, 32'hABCD, 0);
    tick(1, 0, 0, 32'd0, 4'd0, 0, 32'd0, 0);
    check("t6_readback", usb_data, 32'hABCD);
    tick(1, 1, 0, 32'd0, 4'd0, 0, 32'd0, 0);
    idle(1, 0);

    // Randomized bursts with concurrent host traffic.
    for (int b = 0; b < 60; b++) begin
      int kind, n;
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 40);
      if (kind == 0) begin
        tick(1, 0, 0, 32'd0, 4'd0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        for (int i = 0; i < n; i++)
          tick(1, 1, 0, 32'd0, 4'd0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        for (int i = 0; i < n; i++)
          tick(0, 0, 1, $urandom, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end else begin
        for (int i = 0; i < n; i++)
          tick(0, 0, 0, 32'd0, 4'd0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end
      tick(0, 0, 0, 32'd0, 4'd0, 0, 32'd0, 0);
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
